// File: rtl/ternary_pkg.sv
// ternary_pkg: trit codes, trit-to-integer helper and decoder FSM encoding
package ternary_pkg;
    localparam logic [1:0] T_Z   = 2'b00;
    localparam logic [1:0] T_P   = 2'b01;
    localparam logic [1:0] T_N   = 2'b10;
    localparam logic [1:0] T_INV = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    // Invalid code maps to 0 so a bad trit contributes nothing to the value
    function automatic logic signed [1:0] trit_to_int(input logic [1:0] t);
        return t == T_P ? 2'sd1 : t == T_N ? -2'sd1 : 2'sd0;
    endfunction
endpackage

// File: rtl/trit_horner_step.sv
// trit_horner_step: one Horner step acc_out = 3*acc_in + trit, flags invalid trit
//   acc_in  : running signed value
//   trit    : 2-bit trit code
//   acc_out : 3*acc_in + trit value
//   inv     : trit was the invalid code
module trit_horner_step
    import ternary_pkg::*;
#(
    parameter int BIN_W = 15
) (
    input  logic signed [BIN_W-1:0] acc_in,
    input  logic        [1:0]       trit,
    output logic signed [BIN_W-1:0] acc_out,
    output logic                    inv
);
    logic signed [1:0] ti;
    assign ti      = trit_to_int(trit);
    assign acc_out = (acc_in <<< 1) + acc_in + {{(BIN_W-2){ti[1]}}, ti};
    assign inv     = trit == T_INV;
endmodule

// File: rtl/trit_word_decoder.sv
// trit_word_decoder: iterative balanced-ternary word to signed binary converter
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake, in_trits = packed word (trit 0 at [1:0])
//   out_valid/out_ready  : output handshake
//   out_data             : signed two's-complement value
//   out_err              : word held at least one invalid trit
module trit_word_decoder
    import ternary_pkg::*;
#(
    parameter int NTRITS = 9,
    parameter int BIN_W  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*NTRITS-1:0]     in_trits,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [BIN_W-1:0] out_data,
    output logic                    out_err
);
    localparam int CW = $clog2(NTRITS + 1);

    state_t                   state_q, state_d;
    logic [2*NTRITS-1:0]      sh_q, sh_d;
    logic signed [BIN_W-1:0]  acc_q, acc_d, acc_nx, data_q, data_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     err_q, err_d, oerr_q, oerr_d, inv;

    trit_horner_step #(.BIN_W(BIN_W)) u_step (
        .acc_in (acc_q),
        .trit   (sh_q[2*NTRITS-1 -: 2]),
        .acc_out(acc_nx),
        .inv    (inv)
    );

    assign in_ready  = state_q == S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign out_data  = data_q;
    assign out_err   = oerr_q;

    // CONV spends NTRITS clocks stepping and one more publishing the result
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        data_d  = data_q;
        oerr_d  = oerr_q;
        if (state_q == S_IDLE && in_valid) begin
            state_d = S_CONV;
            sh_d    = in_trits;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (state_q == S_CONV && cnt_q == CW'(NTRITS)) begin
            state_d = S_DONE;
            data_d  = acc_q;
            oerr_d  = err_q;
        end else if (state_q == S_CONV) begin
            acc_d = acc_nx;
            sh_d  = {sh_q[2*NTRITS-3:0], 2'b00};
            cnt_d = cnt_q + 1'b1;
            err_d = err_q | inv;
        end else if (state_q == S_DONE && out_ready) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            data_q  <= data_d;
            oerr_q  <= oerr_d;
        end
    end
endmodule

// File: tb/tb_trit_word_decoder.sv
// tb_trit_word_decoder: directed vector bench for trit_word_decoder
module tb_trit_word_decoder;
    logic               clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [17:0]        in_trits = '0;
    logic               in_ready, out_valid, out_err;
    logic signed [14:0] out_data;
    int                 n_chk = 0, n_bad = 0;

    typedef struct {
        logic [17:0]        w;
        logic signed [14:0] d;
        logic               e;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    trit_word_decoder #(.NTRITS(9), .BIN_W(15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_trits(in_trits), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Handshake a word in, then wait for out_valid and check its latency
    task automatic start(input logic [17:0] w);
        int lat;
        @(negedge clk);
        in_trits = w;
        in_valid = 1;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        in_trits = 18'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk("latency", lat, 10);
    endtask

    task automatic finish();
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        chk("out_valid_after_handoff", 32'(out_valid), 0);
        chk("in_ready_after_handoff", 32'(in_ready), 1);
    endtask

    task automatic do_word(input logic [17:0] w, input logic signed [14:0] d, input logic e);
        start(w);
        chk("out_data", 32'(out_data), 32'(d));
        chk("out_err", 32'(out_err), 32'(e));
        finish();
    endtask

    initial begin
        vecs[0] = '{18'h00001,  15'sd1,     1'b0};
        vecs[1] = '{18'h0001A,  15'sd5,     1'b0};
        vecs[2] = '{18'h00002, -15'sd1,     1'b0};
        vecs[3] = '{18'h15555,  15'sd9841,  1'b0};
        vecs[4] = '{18'h2AAAA, -15'sd9841,  1'b0};
        vecs[5] = '{18'h00000,  15'sd0,     1'b0};
        vecs[6] = '{18'h00007,  15'sd3,     1'b1};
        vecs[7] = '{18'h00009, -15'sd2,     1'b0};
        vecs[8] = '{18'h20000, -15'sd6561,  1'b0};
        vecs[9] = '{18'h30001,  15'sd1,     1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_err", 32'(out_err), 0);
        rst = 0;

        for (int i = 0; i < 10; i++) do_word(vecs[i].w, vecs[i].d, vecs[i].e);

        // Error flag clears on the following clean word
        do_word(18'h00007, 15'sd3, 1'b1);
        do_word(18'h10000, 15'sd6561, 1'b0);

        // Backpressure: result held, new input ignored
        start(18'h0001A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1;
            in_trits = 18'h15555;
            chk("bp_out_data", 32'(out_data), 5);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
        end
        @(negedge clk);
        in_valid = 0;
        finish();
        repeat (12) @(negedge clk);
        chk("bp_no_ghost_valid", 32'(out_valid), 0);
        chk("bp_data_held", 32'(out_data), 5);

        // Reset in the middle of a conversion
        do_word(18'h30001, 15'sd1, 1'b1);
        @(negedge clk);
        in_trits = 18'h15555;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_data", 32'(out_data), 0);
        chk("mid_rst_out_err", 32'(out_err), 0);
        begin
            int seen = 0;
            repeat (15) begin
                @(negedge clk);
                if (out_valid) seen = 1;
            end
            chk("mid_rst_no_output", seen, 0);
        end
        do_word(18'h2AAAA, -15'sd9841, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
